// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the mips_core data port and its memory responder.
// The core is the master and drives req_*. The responder is the slave and drives req_ready and rsp_*.
interface mips_mem_responder_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         rsp_valid;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle mips_core data port.
// It serves one word read or write per request after WAIT_STATES wait cycles.
// The address space holds a data RAM window, an LED register and a free-running cycle counter.
// All side effects take place on the edge that enters RESP, and they use the latched request.
module mips_mem_responder #(
    parameter int           N           = 32,
    parameter int           DEPTH_WORDS = 256,
    parameter int           WAIT_STATES = 2,
    parameter logic [N-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [N-1:0] MMIO_ADDR   = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_mem_responder_if.slave   bus,
    output logic [N-1:0]          led_out,
    output logic [N-1:0]          cycle_count
);

    localparam int           IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [N-1:0] RAM_BYTES = N'(4 * DEPTH_WORDS);
    localparam logic [N-1:0] CNT_ADDR  = MMIO_ADDR + N'(4);
    localparam logic [3:0]   WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_ERR = 2'd0,
        K_RAM = 2'd1,
        K_LED = 2'd2,
        K_CNT = 2'd3
    } kind_t;

    // Address decode in priority order. A misaligned address always reports an error.
    function automatic kind_t decode_addr(input logic [N-1:0] a);
        kind_t        k;
        logic [N-1:0] off;
        off = a - BASE_ADDR;
        if (a[1:0] != 2'b00) begin
            k = K_ERR;
        end else if ((a >= BASE_ADDR) && (off < RAM_BYTES)) begin
            k = K_RAM;
        end else if (a == MMIO_ADDR) begin
            k = K_LED;
        end else if (a == CNT_ADDR) begin
            k = K_CNT;
        end else begin
            k = K_ERR;
        end
        return k;
    endfunction

    state_t       state_r;
    logic [3:0]   cnt_r;
    logic         wr_r;
    logic [N-1:0] addr_r;
    logic [N-1:0] wdata_r;
    logic         valid_r;
    logic         ready_r;
    logic [N-1:0] rdata_r;
    logic         err_r;
    logic [N-1:0] led_r;
    logic [N-1:0] cyc_r;

    logic [N-1:0] mem [DEPTH_WORDS];

    logic             accept_s;
    logic             enter_resp_s;
    logic             eff_write_s;
    logic [N-1:0]     eff_addr_s;
    logic [N-1:0]     eff_wdata_s;
    kind_t            kind_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic [N-1:0]     rsp_data_s;
    logic             rsp_err_s;
    logic             ram_we_s;
    logic             led_we_s;

    // Gate accept with rst so that nothing is accepted, and no zero-wait write occurs, while reset is held.
    assign accept_s     = rst && (state_r == ST_IDLE) && bus.req_valid;
    assign enter_resp_s = (accept_s && (WS == 4'd0)) ||
                          ((state_r == ST_WAIT) && (cnt_r <= 4'd1));

    // With zero wait states, the request is served on the edge that accepts it.
    assign eff_write_s = (state_r == ST_IDLE) ? bus.req_write : wr_r;
    assign eff_addr_s  = (state_r == ST_IDLE) ? bus.req_addr  : addr_r;
    assign eff_wdata_s = (state_r == ST_IDLE) ? bus.req_wdata : wdata_r;

    // Decode the effective request into the response value and the write enables.
    always_comb begin
        kind_s     = decode_addr(eff_addr_s);
        ram_idx_s  = IDX_W'((eff_addr_s - BASE_ADDR) >> 2);
        rsp_data_s = {N{1'b0}};
        rsp_err_s  = 1'b1;
        ram_we_s   = 1'b0;
        led_we_s   = 1'b0;
        case (kind_s)
            K_RAM: begin
                rsp_err_s = 1'b0;
                if (eff_write_s) begin
                    ram_we_s = enter_resp_s;
                end else begin
                    rsp_data_s = mem[ram_idx_s];
                end
            end
            K_LED: begin
                rsp_err_s = 1'b0;
                if (eff_write_s) begin
                    led_we_s = enter_resp_s;
                end else begin
                    rsp_data_s = led_r;
                end
            end
            K_CNT: begin
                if (eff_write_s) begin
                    rsp_err_s = 1'b1;
                end else begin
                    rsp_err_s  = 1'b0;
                    rsp_data_s = cyc_r;
                end
            end
            default: begin
                rsp_err_s = 1'b1;
            end
        endcase
    end

    // Request FSM. It also holds the latched request and registers the response and the LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            addr_r  <= {N{1'b0}};
            wdata_r <= {N{1'b0}};
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            rdata_r <= {N{1'b0}};
            err_r   <= 1'b0;
            led_r   <= {N{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (accept_s) begin
                        wr_r    <= bus.req_write;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        cnt_r   <= WS;
                        ready_r <= 1'b0;
                        state_r <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r <= 4'd1) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
            if (enter_resp_s) begin
                valid_r <= 1'b1;
                rdata_r <= rsp_data_s;
                err_r   <= rsp_err_s;
                if (led_we_s) begin
                    led_r <= eff_wdata_s;
                end
            end
        end
    end

    // Free-running cycle counter. It wraps naturally at 2^N.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_r <= {N{1'b0}};
        end else begin
            cyc_r <= cyc_r + {{(N-1){1'b0}}, 1'b1};
        end
    end

    // Data RAM write port. The RAM contents are left out of reset on purpose.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_idx_s] <= eff_wdata_s;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
    assign led_out       = led_r;
    assign cycle_count   = cyc_r;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder.
// It drives requests through the bus interface and compares the DUT with a word-level model of the address map.
module tb_mips_mem_responder;

    localparam int          N     = 32;
    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] led_out;
    logic [31:0] cycle_count;

    mips_mem_responder_if #(.N(N)) bus ();

    mips_mem_responder #(
        .N(N), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE), .MMIO_ADDR(MMIO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .led_out(led_out), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_led = 32'd0;
    logic [31:0] ref_cyc;

    // Reference count of clock edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) ref_cyc <= 32'd0;
        else      ref_cyc <= ref_cyc + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Model of the address map: returns the expected response and applies any write.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] cyc_at_entry,
                                output logic [31:0] exp_rd, output logic exp_err);
        exp_rd  = 32'd0;
        exp_err = 1'b1;
        if (a % 4 != 0) begin
            exp_err = 1'b1;
        end else if (a >= BASE && a < BASE + 4 * DEPTH) begin
            exp_err = 1'b0;
            if (w) model_mem[(a - BASE) / 4] = d;
            else   exp_rd = model_mem[(a - BASE) / 4];
        end else if (a == MMIO) begin
            exp_err = 1'b0;
            if (w) model_led = d;
            else   exp_rd = model_led;
        end else if (a == MMIO + 4) begin
            exp_err = w;
            if (!w) exp_rd = cyc_at_entry;
        end
    endtask

    // Issue one request and wait for its response. Latency is counted in cycles after the accept edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] cyc, output logic [31:0] led);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 40);
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        cyc = ref_cyc;
        led = led_out;
        check_eq("cycle_count", cycle_count, ref_cyc);
        @(negedge clk);
        check_eq("rsp_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, cyc, led, exp_rd;
        logic        er, exp_err;
        int          lat;
        do_req(w, a, d, rd, er, lat, cyc, led);
        model_access(w, a, d, cyc - 32'd1, exp_rd, exp_err);
        check_eq({tag, "_latency"}, lat, WS + 1);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_eq({tag, "_led"}, led, model_led);
    endtask

    initial begin
        logic [31:0] a, d, prev_cnt, rd, cyc, led, exp_rd;
        logic        er, exp_err, seen;
        int          lat, prev;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        // Reset state
        #12;
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check_eq("rst_led", led_out, 32'd0);
        check_eq("rst_cycle", cycle_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rel_ready", {31'd0, bus.req_ready}, 32'd1);

        // Fill the RAM so that every later read has a defined value.
        for (int i = 0; i < DEPTH; i++) xact("fill", 1'b1, BASE + 32'(4 * i), $urandom);

        // Directed: write then read word 2, misaligned write, LED, counter.
        xact("wr8", 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
        xact("rd8", 1'b0, 32'h1000_0008, 32'd0);
        xact("mis_wr", 1'b1, 32'h1000_0002, 32'h1234_5678);
        xact("rd0", 1'b0, 32'h1000_0000, 32'd0);
        xact("led_wr", 1'b1, MMIO, 32'h0000_00A5);
        xact("led_rd", 1'b0, MMIO, 32'd0);
        xact("cnt_wr", 1'b1, MMIO + 32'd4, 32'h5555_5555);
        do_req(1'b0, MMIO + 32'd4, 32'd0, prev_cnt, er, lat, cyc, led);
        check_eq("cnt_rd1", prev_cnt, cyc - 32'd1);
        do_req(1'b0, MMIO + 32'd4, 32'd0, rd, er, lat, cyc, led);
        check_eq("cnt_rd2", rd, cyc - 32'd1);
        check_eq("cnt_increases", {31'd0, rd > prev_cnt}, 32'd1);
        xact("oor_rd", 1'b0, 32'h1000_0400, 32'd0);
        xact("below_rd", 1'b0, 32'h0FFF_FFFC, 32'd0);
        xact("last_wr", 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);
        xact("last_rd", 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0);

        // Randomized mix over every decode class.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                3:       a = MMIO;
                4:       a = MMIO + 32'd4;
                5:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
                default: a = {$urandom} & 32'h7FFF_FFFC;
            endcase
            xact("rand", 1'($urandom), a, $urandom);
        end

        // Back-to-back: req_valid held high, so accepts are spaced WS+2 cycles apart.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = MMIO;
        prev = -1;
        for (int k = 0; k < 30; k++) begin
            if (bus.req_ready) begin
                if (prev >= 0) check_eq("accept_gap", k - prev, WS + 2);
                prev = k;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Abort a write to word 4 while in WAIT.
        d = model_mem[4] ^ 32'hFFFF_FFFF;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h1000_0010;
        bus.req_wdata = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("abort_rdata", bus.rsp_rdata, 32'd0);
        check_eq("abort_err", {31'd0, bus.rsp_err}, 32'd0);
        check_eq("abort_led", led_out, 32'd0);
        check_eq("abort_cycle", cycle_count, 32'd0);
        model_led = 32'd0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        rst = 1'b1;
        #1;
        check_eq("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check_eq("abort_no_rsp", {31'd0, seen}, 32'd0);
        check_eq("post_rst_cycle", cycle_count, 32'd5);
        xact("abort_rd", 1'b0, 32'h1000_0010, 32'd0);
        xact("post_led_rd", 1'b0, MMIO, 32'd0);

        // The model is the sole reference here, so drive one last mixed pair through it directly.
        do_req(1'b0, 32'h1000_0008, 32'd0, rd, er, lat, cyc, led);
        model_access(1'b0, 32'h1000_0008, 32'd0, cyc - 32'd1, exp_rd, exp_err);
        check_eq("final_rd8", rd, exp_rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
